// File: rtl/noc_ni_tx_pkg.sv
// Shared definitions for the NoC transmit interface and router-side flit decode:
// flit geometry, field positions, flit ids and the packetiser state encoding.
package noc_ni_tx_pkg;

    localparam int NOC_DATA_WIDTH = 32;
    localparam int NOC_AXIS       = 4;

    // Field positions inside a 32-bit flit (bit 0 is always the parity bit)
    localparam int ID_W    = 3;
    localparam int ID_LSB  = 29;
    localparam int LEN_W   = 12;
    localparam int LEN_LSB = 17;
    localparam int DST_W   = 4;
    localparam int DST_LSB = 13;
    localparam int SRC_W   = 4;
    localparam int SRC_LSB = 9;
    localparam int SEQ_W   = 8;
    localparam int SEQ_LSB = 1;
    localparam int PAY_W   = 28;
    localparam int PAY_LSB = 1;
    localparam int PAR_BIT = 0;

    localparam logic [ID_W-1:0] FLIT_HEADER = 3'b001;
    localparam logic [ID_W-1:0] FLIT_BODY   = 3'b010;
    localparam logic [ID_W-1:0] FLIT_TAIL   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } ni_state_t;

    // Parity bit that makes the popcount of the whole flit even
    function automatic logic even_parity(input logic [NOC_DATA_WIDTH-1:1] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/noc_flit_fmt.sv
// Combinational flit formatter: places the id and either the header fields or
// the payload word into a flit and appends the even-parity bit.
module noc_flit_fmt
    import noc_ni_tx_pkg::*;
(
    input  logic [ID_W-1:0]           id,
    input  logic [LEN_W-1:0]          len,
    input  logic [DST_W-1:0]          dst,
    input  logic [SRC_W-1:0]          src,
    input  logic [SEQ_W-1:0]          seq,
    input  logic [PAY_W-1:0]          payload,
    output logic [NOC_DATA_WIDTH-1:0] flit
);

    // Everything above the parity bit
    logic [NOC_DATA_WIDTH-1:1] raw;

    // Pack header fields for a header flit, the payload word otherwise
    always_comb begin
        raw = '0;
        raw[ID_LSB +: ID_W] = id;
        if (id == FLIT_HEADER) begin
            raw[LEN_LSB +: LEN_W] = len;
            raw[DST_LSB +: DST_W] = dst;
            raw[SRC_LSB +: SRC_W] = src;
            raw[SEQ_LSB +: SEQ_W] = seq;
        end else begin
            raw[PAY_LSB +: PAY_W] = payload;
        end
    end

    assign flit = {raw, even_parity(raw)};

endmodule

// File: rtl/noc_ni_tx.sv
// Local-port transmit network interface: turns a descriptor plus payload words
// into header/body/tail flits and writes them into the router Local FIFO,
// never issuing a flit at an edge where the router withholds CTS.
module noc_ni_tx
    import noc_ni_tx_pkg::*;
#(
    parameter int DATA_WIDTH = NOC_DATA_WIDTH,
    parameter int AXIS       = NOC_AXIS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXIS-1:0]       cur_addr,
    input  logic                  pkt_valid,
    output logic                  pkt_ready,
    input  logic [AXIS-1:0]       pkt_dst,
    input  logic [LEN_W-1:0]      pkt_len,
    input  logic                  word_valid,
    output logic                  word_ready,
    input  logic [PAY_W-1:0]      word_data,
    output logic                  pkt_err,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_rts,
    input  logic                  tx_cts
);

    ni_state_t             state_q, state_d;
    logic [AXIS-1:0]       dst_q, dst_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      remaining_q, remaining_d;
    logic [SEQ_W-1:0]      seq_q, seq_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_rts_q, tx_rts_d;
    logic                  pkt_err_q, pkt_err_d;

    logic [ID_W-1:0]       fmt_id;
    logic [DATA_WIDTH-1:0] fmt_flit;

    // The last remaining flit of the packet is the tail
    assign fmt_id = (state_q == ST_HDR)      ? FLIT_HEADER :
                    (remaining_q == 12'd1)   ? FLIT_TAIL   : FLIT_BODY;

    noc_flit_fmt u_fmt (
        .id      (fmt_id),
        .len     (len_q),
        .dst     (dst_q),
        .src     (cur_addr),
        .seq     (seq_q),
        .payload (word_data),
        .flit    (fmt_flit)
    );

    assign pkt_ready  = (state_q == ST_IDLE);
    assign word_ready = (state_q == ST_BODY) && tx_cts;
    assign pkt_err    = pkt_err_q;
    assign tx_data    = tx_data_q;
    assign tx_rts     = tx_rts_q;

    // Next-state and flit-issue decisions; strobe and error are single-cycle pulses
    always_comb begin
        state_d     = state_q;
        dst_d       = dst_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        seq_d       = seq_q;
        tx_data_d   = tx_data_q;
        tx_rts_d    = 1'b0;
        pkt_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pkt_valid) begin
                    dst_d = pkt_dst;
                    len_d = pkt_len;
                    if (pkt_len < 12'd2) begin
                        pkt_err_d = 1'b1;
                    end else begin
                        remaining_d = pkt_len - 12'd1;
                        state_d     = ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                if (tx_cts) begin
                    tx_data_d = fmt_flit;
                    tx_rts_d  = 1'b1;
                    seq_d     = seq_q + 8'd1;
                    state_d   = ST_BODY;
                end
            end
            ST_BODY: begin
                if (tx_cts && word_valid) begin
                    tx_data_d   = fmt_flit;
                    tx_rts_d    = 1'b1;
                    remaining_d = remaining_q - 12'd1;
                    if (remaining_q == 12'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any packet in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            dst_q       <= '0;
            len_q       <= '0;
            remaining_q <= '0;
            seq_q       <= '0;
            tx_data_q   <= '0;
            tx_rts_q    <= 1'b0;
            pkt_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            seq_q       <= seq_d;
            tx_data_q   <= tx_data_d;
            tx_rts_q    <= tx_rts_d;
            pkt_err_q   <= pkt_err_d;
        end
    end

endmodule

// File: tb/tb_noc_ni_tx.sv
// Scoreboard bench for noc_ni_tx: expected flits are queued as packets are
// driven and compared as the DUT strobes them onto tx_data.
module tb_noc_ni_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cur_addr;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [3:0]  pkt_dst;
    logic [11:0] pkt_len;
    logic        word_valid;
    logic        word_ready;
    logic [27:0] word_data;
    logic        pkt_err;
    logic [31:0] tx_data;
    logic        tx_rts;
    logic        tx_cts;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          strobe_cnt = 0;
    int          strobe_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  exp_seq = 8'd0;
    logic        cts_last;
    logic        tog_en;

    noc_ni_tx dut (
        .clk        (clk),
        .rst        (rst),
        .cur_addr   (cur_addr),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_dst    (pkt_dst),
        .pkt_len    (pkt_len),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .pkt_err    (pkt_err),
        .tx_data    (tx_data),
        .tx_rts     (tx_rts),
        .tx_cts     (tx_cts)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        cts_last <= tx_cts;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference flit built straight from the field layout
    function automatic logic [31:0] mk_flit(input logic [2:0] id, input logic [11:0] len,
                                            input logic [3:0] dst, input logic [3:0] src,
                                            input logic [7:0] seq, input logic [27:0] pay);
        logic [31:0] f;
        if (id == 3'b001) f = {id, len, dst, src, seq, 1'b0};
        else              f = {id, pay, 1'b0};
        f[0] = ^f[31:1];
        return f;
    endfunction

    // Monitor: every strobe must coincide with CTS, carry even parity and match the scoreboard
    always @(negedge clk) begin
        if (rst && tx_rts) begin
            strobe_q.push_back(cyc);
            strobe_cnt++;
            check("cts_at_edge", {31'd0, cts_last}, 32'd1);
            check("parity", $countones(tx_data) % 2, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_flit", {31'd0, tx_rts}, 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("flit", tx_data, e);
                $display("flit %0d: data=%h expected=%h", strobe_cnt, tx_data, e);
            end
        end
    end

    task automatic push_pkt(input logic [3:0] dst, input logic [11:0] len,
                            input logic [27:0] base, input int nflits);
        exp_q.push_back(mk_flit(3'b001, len, dst, cur_addr, exp_seq, 28'd0));
        exp_seq = exp_seq + 8'd1;
        for (int i = 1; i < nflits; i++)
            exp_q.push_back(mk_flit((i == int'(len) - 1) ? 3'b100 : 3'b010, len, dst,
                                    cur_addr, 8'd0, base + 28'(i - 1)));
    endtask

    task automatic send_desc(input logic [3:0] dst, input logic [11:0] len, output int acc_cyc);
        int   n;
        logic hs;
        n  = 0;
        hs = 1'b0;
        pkt_valid = 1'b1;
        pkt_dst   = dst;
        pkt_len   = len;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = pkt_ready;
            @(posedge clk); #1;
            n++;
        end
        pkt_valid = 1'b0;
        acc_cyc   = cyc;
        if (!hs) check("desc_timeout", 32'd0, 32'd1);
    endtask

    task automatic feed_words(input int nw, input logic [27:0] base);
        for (int i = 0; i < nw; i++) begin
            int   n;
            logic hs;
            n  = 0;
            hs = 1'b0;
            word_valid = 1'b1;
            word_data  = base + 28'(i);
            while (!hs && n < 200) begin
                @(negedge clk);
                hs = word_ready;
                @(posedge clk); #1;
                n++;
            end
            if (!hs) begin
                check("word_timeout", 32'd0, 32'd1);
                break;
            end
        end
        word_valid = 1'b0;
    endtask

    task automatic run_pkt(input logic [3:0] dst, input logic [11:0] len,
                           input logic [27:0] base, output int acc_cyc);
        push_pkt(dst, len, base, int'(len));
        send_desc(dst, len, acc_cyc);
        feed_words(int'(len) - 1, base);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int c1;
        int cnt0;

        rst = 1'b0; cur_addr = 4'h2; pkt_valid = 1'b0; pkt_dst = '0; pkt_len = '0;
        word_valid = 1'b0; word_data = '0; tx_cts = 1'b1; tog_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_pkt_ready", {31'd0, pkt_ready}, 32'd1);
        check("rst_word_ready", {31'd0, word_ready}, 32'd0);
        check("rst_pkt_err", {31'd0, pkt_err}, 32'd0);
        check("rst_tx_rts", {31'd0, tx_rts}, 32'd0);
        check("rst_tx_data", tx_data, 32'd0);
        @(posedge clk); #1;

        // Rejected descriptors: one-cycle error pulse, nothing emitted, sequence untouched
        for (int l = 0; l < 2; l++) begin
            send_desc(4'h5, 12'(l), acc);
            @(negedge clk);
            check("err_pulse", {31'd0, pkt_err}, 32'd1);
            @(posedge clk); #1;
            @(negedge clk);
            check("err_cleared", {31'd0, pkt_err}, 32'd0);
            @(posedge clk); #1;
        end

        // Basic packet: header, body, tail on consecutive cycles
        strobe_q.delete();
        run_pkt(4'h3, 12'd3, 28'h0000001, acc);
        @(negedge clk);
        check("ready_after_tail", {31'd0, pkt_ready}, 32'd1);
        wait_drain();
        check("basic_strobes", strobe_q.size(), 32'd3);
        check("basic_hdr_cyc", strobe_q[0], acc + 1);
        check("basic_body_cyc", strobe_q[1], acc + 2);
        check("basic_tail_cyc", strobe_q[2], acc + 3);

        // CTS stall after accept: no strobes, no word consumption
        strobe_q.delete();
        tx_cts = 1'b0;
        push_pkt(4'h3, 12'd3, 28'h0000001, 3);
        send_desc(4'h3, 12'd3, acc);
        word_valid = 1'b1;
        word_data  = 28'h0000001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_word_ready", {31'd0, word_ready}, 32'd0);
            check("stall_tx_rts", {31'd0, tx_rts}, 32'd0);
            @(posedge clk); #1;
        end
        tx_cts = 1'b1;
        c1 = cyc;
        feed_words(2, 28'h0000001);
        wait_drain();
        check("stall_hdr_cyc", strobe_q[0], c1 + 1);

        // CTS toggling every cycle through a 10-flit packet
        cnt0   = strobe_cnt;
        tog_en = 1'b1;
        fork
            begin
                run_pkt(4'h9, 12'd10, 28'h0ABC000, acc);
                tog_en = 1'b0;
            end
            begin
                while (tog_en) begin
                    @(posedge clk); #1;
                    if (tog_en) tx_cts = ~tx_cts;
                end
            end
        join
        tx_cts = 1'b1;
        wait_drain();
        check("toggle_strobes", strobe_cnt - cnt0, 32'd10);

        // Reset after the second flit of a 5-flit packet
        push_pkt(4'h7, 12'd5, 28'h0000100, 2);
        send_desc(4'h7, 12'd5, acc);
        feed_words(1, 28'h0000100);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check("abort_tx_rts", {31'd0, tx_rts}, 32'd0);
        check("abort_tx_data", tx_data, 32'd0);
        check("abort_word_ready", {31'd0, word_ready}, 32'd0);
        check("abort_flits_seen", exp_q.size(), 32'd0);
        exp_q.delete();
        exp_seq = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // 257 minimum-length packets: sequence runs 0..255 and wraps to 0
        for (int p = 0; p < 257; p++)
            run_pkt(4'(p), 12'd2, 28'(p * 3 + 7), acc);
        wait_drain();
        check("seq_wrapped", {24'd0, exp_seq}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
